nl2_dbank_bresp_gen: RTL and testbench
======================================

Name: nl2_dbank_bresp_gen

Overview:
- Write-response stage directly downstream of the dbank exclusive monitor, on the dbank AXI write path.
- Samples the monitor's `excl_err` on every accepted AW command and queues one response entry per command in an in-order FIFO.
- Drops (kills) failed exclusive writes toward the bank.
- Returns BID/BRESP on the AXI B channel once the bank has completed the write, or immediately for killed writes.

Parameters:
- `WR_ID_SIZE`, 1, AXI write ID width (>=1).
- `DEPTH`, 4, outstanding write responses; power of 2, >=2.
- `CNT_W`, $clog2(DEPTH)+1, derived width of the completion counter; not overridable.

Ports:
- `axi_clk`  in  1  clock
- `rst_a`  in  1  reset, asynchronous, active-high
- `axi_awvalid`  in  1  AW valid from master
- `axi_awlock`  in  1  AW exclusive flag
- `axi_awid`  in  WR_ID_SIZE  AW ID
- `bnk_awready`  in  1  bank ready for AW
- `axi_awready`  out  1  AW ready to master, also fed to exclusive monitor
- `excl_err`  in  2  from exclusive monitor, combinational in the AW cycle; bit1=exclusive fail
- `bnk_cmd_kill`  out  1  registered pulse: the command accepted in the previous cycle must not update memory
- `bnk_wr_done`  in  1  pulse: bank finished the oldest non-killed write (in order)
- `axi_bvalid`  out  1  B valid
- `axi_bready`  in  1  B ready
- `axi_bid`  out  WR_ID_SIZE  B ID
- `axi_bresp`  out  2  B response (00 OKAY, 01 EXOKAY)
- `resp_overflow_err`  out  1  sticky: `bnk_wr_done` arrived with no non-killed write outstanding

Behaviour:
- **Handshake.**
  - `axi_awready = bnk_awready & !full`.
  - AW accept (push) = `axi_awvalid & axi_awready`.
  - `full` is evaluated on registered state only; no push when full, even if a pop occurs in the same cycle.
- **Entry contents on push:** {id=`axi_awid`, resp, kill}.
  - `awlock=0`: resp=00, kill=0.
  - `awlock=1`, `excl_err[1]=0`: resp=01 (EXOKAY), kill=0.
  - `awlock=1`, `excl_err[1]=1`: resp=00, kill=1.
- **`bnk_cmd_kill`.** Set one cycle after a push with kill=1, for exactly one cycle; otherwise 0.
- **FIFO.** DEPTH entries with wr/rd pointers one bit wider than the index.
  - full = MSBs differ and index bits equal.
  - empty = pointers equal.
  - Pointers wrap naturally.
- **Completion counter `done_cnt` (CNT_W bits).**
  - +1 on `bnk_wr_done`.
  - -1 on a B handshake of a non-killed head entry.
  - Both in the same cycle: unchanged.
- **`live_cnt`.** Number of non-killed entries queued minus `done_cnt`.
  - If `bnk_wr_done` arrives while `live_cnt==0`: the pulse is ignored and `resp_overflow_err` is set. It clears only on reset.
- **B channel.**
  - `axi_bvalid = !empty & (head.kill | done_cnt!=0)`.
  - `axi_bid` and `axi_bresp` come from the head entry.
  - All B outputs are driven from registers only, with no path from `axi_awvalid`.
  - Once asserted, `axi_bvalid` and its payload stay stable until `axi_bready`.
  - Pop on `axi_bvalid & axi_bready`.
- **Latency.**
  - Killed write: earliest `axi_bvalid` is the cycle after the AW accept.
  - Normal write: earliest `axi_bvalid` is the cycle after `bnk_wr_done`.
- **Simultaneous push and pop (not full).** Both take effect; occupancy is unchanged.
- **Reset (including mid-operation).** Applies immediately and asynchronously:
  - pointers=0, `done_cnt`=0;
  - `axi_bvalid`=0, `bnk_cmd_kill`=0, `resp_overflow_err`=0;
  - `axi_bid`=0, `axi_bresp`=00;
  - `axi_awready` follows `bnk_awready` (FIFO empty).
  - In-flight entries are discarded.

Decomposition:
- **Shared package `nl2_dbank_pkg`:**
  - `AXI_RESP_OKAY`=2'b00, `AXI_RESP_EXOKAY`=2'b01;
  - `EXCL_ERR_FAIL_BIT`=1;
  - typedef `bresp_entry_t` {id, resp[1:0], kill}. ID width comes from the module parameter, so the typedef is parameterised via a macro or declared locally.
- **Sub-module:** one natural sub-module, `nl2_dbank_bresp_fifo`, a generic sync FIFO with push/pop/full/empty and registered head output. The top holds the classification logic, the kill pulse, `done_cnt` and the error flag.

Test Plan:
1. Non-exclusive write ID=1, `bnk_wr_done` 3 cycles later, `axi_bready`=1 → `axi_bvalid` the cycle after done, `axi_bid`=1, `axi_bresp`=00, `bnk_cmd_kill` never set.
2. Exclusive write ID=0 with `excl_err`=00, then done → `axi_bresp`=01. Exclusive write with `excl_err`=10 → `bnk_cmd_kill` pulse 1 cycle after accept, `axi_bresp`=00 next cycle, no done required.
3. Push 4 writes with `bnk_awready`=1 and no done (DEPTH=4) → `axi_awready`=0 on the 5th attempt. Pop one (after a done) → `axi_awready` returns 1 the following cycle; ordering of IDs preserved across pointer wrap.
4. Mixed order: normal A, killed B, normal C. Two `bnk_wr_done` pulses arrive before any B response, `axi_bready` toggling → responses A(00), B(00), C(01 if exclusive OK) strictly in order, payload stable while `axi_bready`=0.
5. `bnk_wr_done` in the same cycle as a B handshake of a normal head, with another normal entry queued → `done_cnt` unchanged, next response issued without waiting. `bnk_wr_done` with queue empty → `resp_overflow_err`=1 and sticky.
6. Assert `rst_a` mid-burst with 3 entries queued and `axi_bvalid`=1 → `axi_bvalid`=0 immediately, FIFO empty, `resp_overflow_err`=0. After deassertion a fresh write completes normally.

Source files
------------

// File: rtl/nl2_dbank_pkg.sv
// Shared definitions for the dbank write-response path.
// Holds the AXI response codes, the exclusive-monitor error bit position
// and the AW classification helper used when a response entry is queued.
package nl2_dbank_pkg;

    localparam int unsigned RESP_W            = 2;
    localparam int unsigned EXCL_ERR_W        = 2;
    localparam int unsigned EXCL_ERR_FAIL_BIT = 1;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;

    // Response code and kill decision for one AW command; the ID-carrying
    // entry type depends on the ID width, so it is declared in the top.
    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic              kill;
    } bresp_cls_t;

    // Classify an accepted AW: plain writes get OKAY, exclusive writes that
    // the monitor passed get EXOKAY, failed exclusives are killed with OKAY.
    function automatic bresp_cls_t classify_aw(input logic                  awlock,
                                               input logic [EXCL_ERR_W-1:0] excl_err);
        bresp_cls_t cls;
        cls.resp = AXI_RESP_OKAY;
        cls.kill = 1'b0;
        if (awlock) begin
            if (excl_err[EXCL_ERR_FAIL_BIT]) begin
                cls.kill = 1'b1;
            end else begin
                cls.resp = AXI_RESP_EXOKAY;
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/nl2_dbank_bresp_gen_if.sv
// Signal bundle between the AXI master, exclusive monitor, bank and the
// write-response generator.
//   slave  : the response generator (consumes AW/B-ready/bank status,
//            produces AW-ready, kill, B channel and the overflow flag)
//   master : the surrounding environment (master, monitor and bank side)
interface nl2_dbank_bresp_gen_if #(
    parameter int unsigned WR_ID_SIZE = 1
);
    import nl2_dbank_pkg::*;

    logic                  axi_awvalid;
    logic                  axi_awlock;
    logic [WR_ID_SIZE-1:0] axi_awid;
    logic                  bnk_awready;
    logic                  axi_awready;
    logic [EXCL_ERR_W-1:0] excl_err;
    logic                  bnk_cmd_kill;
    logic                  bnk_wr_done;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [WR_ID_SIZE-1:0] axi_bid;
    logic [RESP_W-1:0]     axi_bresp;
    logic                  resp_overflow_err;

    modport slave (
        input  axi_awvalid, axi_awlock, axi_awid, bnk_awready, excl_err,
               bnk_wr_done, axi_bready,
        output axi_awready, bnk_cmd_kill, axi_bvalid, axi_bid, axi_bresp,
               resp_overflow_err
    );

    modport master (
        output axi_awvalid, axi_awlock, axi_awid, bnk_awready, excl_err,
               bnk_wr_done, axi_bready,
        input  axi_awready, bnk_cmd_kill, axi_bvalid, axi_bid, axi_bresp,
               resp_overflow_err
    );

endinterface

// File: rtl/nl2_dbank_bresp_fifo.sv
// Generic synchronous in-order FIFO.
// Ports:
//   axi_clk, rst_a : clock, asynchronous active-high reset
//   push, din      : write request and data (ignored while full)
//   pop            : read request (ignored while empty)
//   dout           : head entry, read straight from the storage registers
//   full, empty    : status decoded from the registered pointers only
module nl2_dbank_bresp_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              axi_clk,
    input  logic              rst_a,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    // Extra pointer MSB separates the full and empty cases when indices match.
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign dout = mem[rd_ptr[IDX_W-1:0]];

    // Pointer update; both ends may move in the same cycle.
    always_ff @(posedge axi_clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage; stale contents are harmless because the reader qualifies them.
    always_ff @(posedge axi_clk) begin
        if (push_ok) begin
            mem[wr_ptr[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/nl2_dbank_bresp_gen.sv
// dbank write-response generator, downstream of the exclusive monitor.
// Queues one response entry per accepted AW, kills failed exclusive writes
// toward the bank and returns BID/BRESP in order once the bank has finished
// the write (or right away for killed writes).
// Ports:
//   axi_clk, rst_a : clock, asynchronous active-high reset
//   bus (slave)    : AW handshake and exclusive-monitor status, bank ready,
//                    kill pulse and write-done, AXI B channel, sticky
//                    response-overflow error
module nl2_dbank_bresp_gen
    import nl2_dbank_pkg::*;
#(
    parameter int unsigned WR_ID_SIZE = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  axi_clk,
    input  logic                  rst_a,
    nl2_dbank_bresp_gen_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WR_ID_SIZE-1:0] id;
        logic [RESP_W-1:0]     resp;
        logic                  kill;
    } bresp_entry_t;

    localparam int unsigned ENTRY_W = $bits(bresp_entry_t);

    bresp_cls_t   aw_cls;
    bresp_entry_t push_entry;
    bresp_entry_t head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         push_live;
    logic         pop_live;
    logic         bvalid_int;
    logic         no_live;
    logic         done_ok;
    logic         kill_q;
    logic         overflow_q;
    logic [CNT_W-1:0] done_cnt;
    logic [CNT_W-1:0] nk_cnt;

    // AW acceptance; full comes from registered pointers only.
    assign bus.axi_awready = bus.bnk_awready & ~full;
    assign push            = bus.axi_awvalid & bus.axi_awready;

    assign aw_cls          = classify_aw(bus.axi_awlock, bus.excl_err);
    assign push_entry.id   = bus.axi_awid;
    assign push_entry.resp = aw_cls.resp;
    assign push_entry.kill = aw_cls.kill;

    nl2_dbank_bresp_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .axi_clk (axi_clk),
        .rst_a   (rst_a),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty)
    );

    // B valid decodes only flop state, so it holds until the handshake pops.
    assign bvalid_int = ~empty & (head.kill | (done_cnt != '0));
    assign pop        = bvalid_int & bus.axi_bready;
    assign pop_live   = pop & ~head.kill;
    assign push_live  = push & ~aw_cls.kill;

    // A completion is only credible if some non-killed write is still
    // waiting for one (queued non-killed entries exceed collected dones).
    assign no_live = (nk_cnt == done_cnt);
    assign done_ok = bus.bnk_wr_done & ~no_live;

    assign bus.axi_bvalid        = bvalid_int;
    assign bus.axi_bid           = bvalid_int ? head.id   : '0;
    assign bus.axi_bresp         = bvalid_int ? head.resp : AXI_RESP_OKAY;
    assign bus.bnk_cmd_kill      = kill_q;
    assign bus.resp_overflow_err = overflow_q;

    // Kill pulse and sticky overflow flag.
    always_ff @(posedge axi_clk or posedge rst_a) begin
        if (rst_a) begin
            kill_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            kill_q     <= push & aw_cls.kill;
            overflow_q <= overflow_q | (bus.bnk_wr_done & no_live);
        end
    end

    // Completions collected but not yet returned on B.
    always_ff @(posedge axi_clk or posedge rst_a) begin
        if (rst_a) begin
            done_cnt <= '0;
        end else begin
            case ({done_ok, pop_live})
                2'b10:   done_cnt <= done_cnt + CNT_W'(1);
                2'b01:   done_cnt <= done_cnt - CNT_W'(1);
                default: done_cnt <= done_cnt;
            endcase
        end
    end

    // Non-killed entries currently in the FIFO.
    always_ff @(posedge axi_clk or posedge rst_a) begin
        if (rst_a) begin
            nk_cnt <= '0;
        end else begin
            case ({push_live, pop_live})
                2'b10:   nk_cnt <= nk_cnt + CNT_W'(1);
                2'b01:   nk_cnt <= nk_cnt - CNT_W'(1);
                default: nk_cnt <= nk_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_nl2_dbank_bresp_gen.sv
// Self-checking bench for nl2_dbank_bresp_gen: a vector table for the AW
// classification and latency, hand sequences for fill/wrap, ordering,
// same-cycle done/pop, overflow and mid-burst reset, with a B-channel
// scoreboard fed at stimulus time.
module tb_nl2_dbank_bresp_gen;

    localparam int unsigned IDW = 2;

    logic axi_clk;
    logic rst_a;

    nl2_dbank_bresp_gen_if #(.WR_ID_SIZE(IDW)) bus ();

    nl2_dbank_bresp_gen #(
        .WR_ID_SIZE (IDW),
        .DEPTH      (4)
    ) u_dut (
        .axi_clk (axi_clk),
        .rst_a   (rst_a),
        .bus     (bus)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } exp_t;

    typedef struct {
        logic           lock;
        logic [1:0]     err;
        logic [IDW-1:0] id;
        int             dly;
        logic [1:0]     exp_resp;
        logic           exp_kill;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int n_checks   = 0;
    int n_pass     = 0;
    int exp_kills  = 0;
    int kills_seen = 0;

    logic           hold;
    logic [IDW-1:0] hold_id;
    logic [1:0]     hold_resp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic done_pulse();
        bus.bnk_wr_done = 1'b1;
        tick();
        bus.bnk_wr_done = 1'b0;
    endtask

    // Drive one AW until accepted; expected B response is queued up front.
    task automatic do_aw(input logic lock, input logic [1:0] err, input logic [IDW-1:0] id,
                         input logic [1:0] eresp, input logic ekill);
        exp_t e;
        logic acc;
        e.id   = id;
        e.resp = eresp;
        sb.push_back(e);
        if (ekill) exp_kills++;
        bus.axi_awvalid = 1'b1;
        bus.axi_awlock  = lock;
        bus.axi_awid    = id;
        bus.excl_err    = err;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            acc = bus.axi_awready;
            tick();
        end
        bus.axi_awvalid = 1'b0;
        bus.axi_awlock  = 1'b0;
        bus.excl_err    = 2'b00;
        if (!acc) begin
            n_checks++;
            $display("FAIL aw_accept: awready never seen for id %0d", id);
        end else begin
            chk("aw_kill_pulse", 32'(bus.bnk_cmd_kill), 32'(ekill));
        end
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d responses still outstanding, expected 0", name, sb.size());
        end
    endtask

    // B-channel scoreboard, payload stability and kill pulse counting.
    always @(negedge axi_clk) begin
        if (rst_a) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("b_hold_valid", 32'(bus.axi_bvalid), 32'd1);
                chk("b_hold_id",    32'(bus.axi_bid),    32'(hold_id));
                chk("b_hold_resp",  32'(bus.axi_bresp),  32'(hold_resp));
            end
            hold      = bus.axi_bvalid & ~bus.axi_bready;
            hold_id   = bus.axi_bid;
            hold_resp = bus.axi_bresp;
            if (bus.axi_bvalid && bus.axi_bready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL b_unexpected: response id %0d resp %0d with none expected",
                             bus.axi_bid, bus.axi_bresp);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("b_id",   32'(bus.axi_bid),   32'(e.id));
                    chk("b_resp", 32'(bus.axi_bresp), 32'(e.resp));
                end
            end
            if (bus.bnk_cmd_kill) kills_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{lock:1'b0, err:2'b00, id:2'd1, dly:2, exp_resp:2'b00, exp_kill:1'b0};
        vecs[1] = '{lock:1'b1, err:2'b00, id:2'd0, dly:0, exp_resp:2'b01, exp_kill:1'b0};
        vecs[2] = '{lock:1'b1, err:2'b10, id:2'd2, dly:0, exp_resp:2'b00, exp_kill:1'b1};
        vecs[3] = '{lock:1'b0, err:2'b10, id:2'd3, dly:1, exp_resp:2'b00, exp_kill:1'b0};
        vecs[4] = '{lock:1'b1, err:2'b01, id:2'd1, dly:0, exp_resp:2'b01, exp_kill:1'b0};
        vecs[5] = '{lock:1'b1, err:2'b11, id:2'd3, dly:0, exp_resp:2'b00, exp_kill:1'b1};

        rst_a           = 1'b1;
        bus.axi_awvalid = 1'b0;
        bus.axi_awlock  = 1'b0;
        bus.axi_awid    = '0;
        bus.bnk_awready = 1'b1;
        bus.excl_err    = 2'b00;
        bus.bnk_wr_done = 1'b0;
        bus.axi_bready  = 1'b1;
        #3;
        chk("rst_bvalid",   32'(bus.axi_bvalid),        32'd0);
        chk("rst_kill",     32'(bus.bnk_cmd_kill),      32'd0);
        chk("rst_ovf",      32'(bus.resp_overflow_err), 32'd0);
        chk("rst_awready",  32'(bus.axi_awready),       32'd1);
        repeat (2) @(posedge axi_clk);
        #3 rst_a = 1'b0;
        tick();

        // Classification and latency vectors, one write at a time.
        foreach (vecs[i]) begin
            do_aw(vecs[i].lock, vecs[i].err, vecs[i].id, vecs[i].exp_resp, vecs[i].exp_kill);
            if (vecs[i].exp_kill) begin
                chk("vec_kill_bvalid", 32'(bus.axi_bvalid), 32'd1);
                chk("vec_kill_bid",    32'(bus.axi_bid),    32'(vecs[i].id));
                chk("vec_kill_bresp",  32'(bus.axi_bresp),  32'(vecs[i].exp_resp));
                tick();
                chk("vec_kill_one_cycle", 32'(bus.bnk_cmd_kill), 32'd0);
            end else begin
                chk("vec_wait_bvalid", 32'(bus.axi_bvalid), 32'd0);
                repeat (vecs[i].dly) tick();
                done_pulse();
                chk("vec_bvalid", 32'(bus.axi_bvalid), 32'd1);
                chk("vec_bid",    32'(bus.axi_bid),    32'(vecs[i].id));
                chk("vec_bresp",  32'(bus.axi_bresp),  32'(vecs[i].exp_resp));
                tick();
            end
            chk("vec_popped", 32'(bus.axi_bvalid), 32'd0);
        end
        wait_drain("vec_drain");

        // Fill to DEPTH, blocked fifth AW, release by one pop, order across wrap.
        bus.axi_bready = 1'b0;
        for (int i = 0; i < 4; i++) do_aw(1'b0, 2'b00, IDW'(i + 1), 2'b00, 1'b0);
        chk("full_awready", 32'(bus.axi_awready), 32'd0);
        begin
            exp_t e;
            e.id   = 2'd1;
            e.resp = 2'b00;
            sb.push_back(e);
        end
        bus.axi_awvalid = 1'b1;
        bus.axi_awid    = 2'd1;
        tick();
        chk("full_blocked", 32'(bus.axi_awready), 32'd0);
        done_pulse();
        chk("full_head_valid", 32'(bus.axi_bvalid),  32'd1);
        chk("full_still_full", 32'(bus.axi_awready), 32'd0);
        bus.axi_bready = 1'b1;
        tick();
        chk("full_released", 32'(bus.axi_awready), 32'd1);
        tick();
        bus.axi_awvalid = 1'b0;
        repeat (4) begin
            done_pulse();
            tick();
        end
        wait_drain("wrap_drain");

        // In-order mix: normal A, killed B, exclusive-OK C, toggling bready.
        bus.axi_bready = 1'b0;
        do_aw(1'b0, 2'b00, 2'd1, 2'b00, 1'b0);
        do_aw(1'b1, 2'b10, 2'd2, 2'b00, 1'b1);
        do_aw(1'b1, 2'b00, 2'd3, 2'b01, 1'b0);
        chk("mix_wait", 32'(bus.axi_bvalid), 32'd0);
        done_pulse();
        done_pulse();
        for (int c = 0; c < 30 && sb.size() != 0; c++) begin
            bus.axi_bready = c[0];
            tick();
        end
        bus.axi_bready = 1'b1;
        wait_drain("mix_drain");
        chk("mix_no_ovf", 32'(bus.resp_overflow_err), 32'd0);

        // Done coinciding with a normal pop keeps the next response ready.
        bus.axi_bready = 1'b0;
        do_aw(1'b0, 2'b00, 2'd1, 2'b00, 1'b0);
        do_aw(1'b0, 2'b00, 2'd2, 2'b00, 1'b0);
        done_pulse();
        chk("sim_head", 32'(bus.axi_bid), 32'd1);
        bus.axi_bready  = 1'b1;
        bus.bnk_wr_done = 1'b1;
        tick();
        bus.bnk_wr_done = 1'b0;
        chk("sim_next_valid", 32'(bus.axi_bvalid), 32'd1);
        chk("sim_next_id",    32'(bus.axi_bid),    32'd2);
        tick();
        chk("sim_empty", 32'(bus.axi_bvalid), 32'd0);
        wait_drain("sim_drain");

        // Spurious done with nothing outstanding: sticky error, no credit.
        chk("ovf_before", 32'(bus.resp_overflow_err), 32'd0);
        done_pulse();
        chk("ovf_set", 32'(bus.resp_overflow_err), 32'd1);
        do_aw(1'b0, 2'b00, 2'd3, 2'b00, 1'b0);
        chk("ovf_no_credit_a", 32'(bus.axi_bvalid), 32'd0);
        tick();
        chk("ovf_no_credit_b", 32'(bus.axi_bvalid), 32'd0);
        chk("ovf_sticky",      32'(bus.resp_overflow_err), 32'd1);
        done_pulse();
        chk("ovf_after_done", 32'(bus.axi_bvalid), 32'd1);
        wait_drain("ovf_drain");

        // Reset mid-burst with three entries queued and B valid.
        bus.axi_bready = 1'b0;
        do_aw(1'b0, 2'b00, 2'd1, 2'b00, 1'b0);
        do_aw(1'b0, 2'b00, 2'd2, 2'b00, 1'b0);
        do_aw(1'b0, 2'b00, 2'd3, 2'b00, 1'b0);
        done_pulse();
        chk("pre_rst_bvalid", 32'(bus.axi_bvalid), 32'd1);
        #2 rst_a = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_bvalid",  32'(bus.axi_bvalid),        32'd0);
        chk("mid_rst_bid",     32'(bus.axi_bid),           32'd0);
        chk("mid_rst_bresp",   32'(bus.axi_bresp),         32'd0);
        chk("mid_rst_ovf",     32'(bus.resp_overflow_err), 32'd0);
        chk("mid_rst_awready", 32'(bus.axi_awready),       32'd1);
        bus.bnk_awready = 1'b0;
        #1;
        chk("mid_rst_awready_follow", 32'(bus.axi_awready), 32'd0);
        bus.bnk_awready = 1'b1;
        @(posedge axi_clk);
        #3 rst_a = 1'b0;
        tick();
        do_aw(1'b1, 2'b00, 2'd2, 2'b01, 1'b0);
        chk("post_rst_wait", 32'(bus.axi_bvalid), 32'd0);
        done_pulse();
        chk("post_rst_bvalid", 32'(bus.axi_bvalid), 32'd1);
        chk("post_rst_bid",    32'(bus.axi_bid),    32'd2);
        chk("post_rst_bresp",  32'(bus.axi_bresp),  32'd1);
        bus.axi_bready = 1'b1;
        wait_drain("post_rst_drain");
        tick();
        chk("post_rst_empty", 32'(bus.axi_bvalid), 32'd0);

        chk("kill_count", 32'(kills_seen), 32'(exp_kills));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
